// File: rtl/lsu_wb_ctrl.sv
// Load/store and writeback control between the M and W stages of the RISC-V pipeline.
// Define MISALIGN_SPLIT_EN to split boundary-crossing misaligned accesses into two beats.
//
// state   | meaning
// IDLE    | accept next instruction; non-memory ops retire next cycle
// ACCESS  | first (or only) memory beat outstanding, waiting for mem_ack
// ACCESS2 | second beat of a split access (MISALIGN_SPLIT_EN only)
// RESP    | done pulse with writeback controls, back to IDLE
module lsu_wb_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int BE_W   = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              stall,
    output logic              done,
    output logic              rd_we,
    output logic [4:0]        rd_addr,
    output logic [1:0]        wb_sel,
    output logic [XLEN-1:0]   rdata_out,
    output logic              misalign_err,
    output logic              illegal_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int OFF_W = $clog2(BE_W);
`ifdef MISALIGN_SPLIT_EN
    localparam int BEATS = 2;
`else
    localparam int BEATS = 1;
`endif

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_IMM   = 5'b00100;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
`ifdef MISALIGN_SPLIT_EN
    localparam logic [1:0] ACCESS2 = 2'd2;
`endif
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]       state;
    logic [2:0]       f3_q;
    logic [4:0]       rd_q;
    logic             load_q;
    logic [OFF_W-1:0] off_q;

    logic [4:0]       opc, rd;
    logic [2:0]       f3;
    logic [OFF_W-1:0] off, cur_off;
    logic [1:0]       cur_sz;
    logic [XLEN-1:0]  cur_wdata;
    logic             is_load, is_store, is_mem, illegal, misal, misal_fault, last_ack;
    logic [2:0]       amask;
    logic [BE_W-1:0]  mask;
    logic [BEATS*BE_W-1:0] be_wide;
    logic [BEATS*XLEN-1:0] wd_wide, rd_wide;
    logic [XLEN-1:0]  load_val;
    logic             nm_we;
    logic [1:0]       nm_sel;
    logic             unused_inst;

    assign opc         = inst[6:2];
    assign f3          = inst[14:12];
    assign rd          = inst[11:7];
    assign off         = addr[OFF_W-1:0];
    assign unused_inst = ^{inst[31:15], inst[1:0]};
    assign is_load     = (opc == OP_LOAD);
    assign is_store    = (opc == OP_STORE);
    assign is_mem      = is_load || is_store;
    assign stall       = (state != IDLE) || (inst_valid && is_mem);

    always_comb begin
        illegal = 1'b0;
        if (is_load)
            illegal = (f3 == 3'b111) || ((XLEN == 32) && (f3 == 3'b011 || f3 == 3'b110));
        else
            illegal = f3[2] || ((XLEN == 32) && (f3[1:0] == 2'b11));
        case (f3[1:0])
            2'd0:    amask = 3'b000;
            2'd1:    amask = 3'b001;
            2'd2:    amask = 3'b011;
            default: amask = 3'b111;
        endcase
        misal = ((3'(off) & amask) != 3'b000);
    end

`ifdef MISALIGN_SPLIT_EN
    logic [XLEN-1:0] wdata_q, rlo_q;
    logic            split_q, need_split, next_beat;

    // The second beat re-derives its lanes from the latched access.
    assign cur_sz      = (state == IDLE) ? f3[1:0] : f3_q[1:0];
    assign cur_off     = (state == IDLE) ? off : off_q;
    assign cur_wdata   = (state == IDLE) ? wdata : wdata_q;
    assign need_split  = misal && ((int'(off) + (1 << f3[1:0])) > BE_W);
    assign misal_fault = 1'b0;
    assign next_beat   = mem_ack && (state == ACCESS) && split_q;
    assign last_ack    = mem_ack && (((state == ACCESS) && !split_q) || (state == ACCESS2));
    assign rd_wide     = (state == ACCESS2) ? {mem_rdata, rlo_q} : {{XLEN{1'b0}}, mem_rdata};
`else
    assign cur_sz      = f3[1:0];
    assign cur_off     = off;
    assign cur_wdata   = wdata;
    assign misal_fault = misal;
    assign last_ack    = mem_ack && (state == ACCESS);
    assign rd_wide     = mem_rdata;
`endif

    always_comb begin
        case (cur_sz)
            2'd0:    mask = BE_W'(1);
            2'd1:    mask = BE_W'(3);
            2'd2:    mask = BE_W'(15);
            default: mask = '1;
        endcase
        be_wide  = (BEATS*BE_W)'(mask) << cur_off;
        wd_wide  = (BEATS*XLEN)'(cur_wdata) << {cur_off, 3'b000};
        load_val = XLEN'(rd_wide >> {off_q, 3'b000});
    end

    always_comb begin
        nm_we  = 1'b0;
        nm_sel = 2'b01;
        case (opc)
            OP_R, OP_IMM:    nm_we = 1'b1;
            OP_JAL, OP_JALR: begin nm_we = 1'b1; nm_sel = 2'b10; end
            default:         nm_we = 1'b0;
        endcase
    end

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [2:0] fn);
        logic [XLEN-1:0] keep;
        logic            s;
        case (fn[1:0])
            2'd0:    begin keep = XLEN'(8'hFF);         s = v[7];  end
            2'd1:    begin keep = XLEN'(16'hFFFF);      s = v[15]; end
            2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); s = v[31]; end
            default: begin keep = '1;                   s = 1'b0;  end
        endcase
        return (v & keep) | ({XLEN{s & ~fn[2]}} & ~keep);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE; f3_q <= '0; rd_q <= '0; load_q <= 1'b0; off_q <= '0;
            done <= 1'b0; rd_we <= 1'b0; rd_addr <= '0; wb_sel <= '0; rdata_out <= '0;
            misalign_err <= 1'b0; illegal_err <= 1'b0;
            mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_be <= '0; mem_wdata <= '0;
`ifdef MISALIGN_SPLIT_EN
            wdata_q <= '0; rlo_q <= '0; split_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0; rd_we <= 1'b0; misalign_err <= 1'b0; illegal_err <= 1'b0;
            if (state == IDLE && inst_valid && !is_mem) begin
                done <= 1'b1; rd_addr <= rd; rd_we <= nm_we && (rd != 5'd0);
                wb_sel <= nm_sel; rdata_out <= '0;
            end else if (state == IDLE && inst_valid) begin
                f3_q <= f3; rd_q <= rd; load_q <= is_load; off_q <= off;
`ifdef MISALIGN_SPLIT_EN
                wdata_q <= wdata; split_q <= need_split;
`endif
                if (illegal || misal_fault) begin
                    state <= RESP; done <= 1'b1; rd_addr <= rd; wb_sel <= 2'b00; rdata_out <= '0;
                    illegal_err <= illegal; misalign_err <= !illegal;
                end else begin
                    state <= ACCESS; mem_req <= 1'b1; mem_we <= is_store;
                    mem_addr <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    mem_be <= be_wide[BE_W-1:0];
                    mem_wdata <= is_store ? wd_wide[XLEN-1:0] : '0;
                end
`ifdef MISALIGN_SPLIT_EN
            end else if (next_beat) begin
                state <= ACCESS2; rlo_q <= mem_rdata;
                mem_addr <= mem_addr + ADDR_W'(BE_W);
                mem_be <= be_wide[2*BE_W-1:BE_W];
                mem_wdata <= mem_we ? wd_wide[2*XLEN-1:XLEN] : '0;
`endif
            end else if (last_ack) begin
                state <= RESP; mem_req <= 1'b0; done <= 1'b1; rd_addr <= rd_q;
                rd_we <= load_q && (rd_q != 5'd0); wb_sel <= 2'b00;
                rdata_out <= load_q ? extend(load_val, f3_q) : '0;
            end else if (state == RESP) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_lsu_wb_ctrl.sv
// Directed bench for lsu_wb_ctrl: XLEN=32 instance plus an XLEN=64 instance for LWU.
module tb_lsu_wb_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv, ack, stall, done, rd_we, mis, ill, mem_req, mem_we;
    logic [31:0] inst, addr, wdata, rdata, rdata_out, mem_addr, mem_wdata;
    logic [4:0]  rd_addr;
    logic [1:0]  wb_sel;
    logic [3:0]  mem_be;

    logic        iv6, ack6, stall6, done6, rd_we6, mis6, ill6, mem_req6, mem_we6;
    logic [31:0] inst6, addr6, mem_addr6;
    logic [63:0] wdata6, rdata6, rdata_out6, mem_wdata6;
    logic [4:0]  rd_addr6;
    logic [1:0]  wb_sel6;
    logic [7:0]  mem_be6;

    int total = 0;
    int bad = 0;

    lsu_wb_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(iv), .inst(inst), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rd_we(rd_we), .rd_addr(rd_addr), .wb_sel(wb_sel),
        .rdata_out(rdata_out), .misalign_err(mis), .illegal_err(ill), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(ack), .mem_rdata(rdata)
    );

    lsu_wb_ctrl #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .inst_valid(iv6), .inst(inst6), .addr(addr6), .wdata(wdata6),
        .stall(stall6), .done(done6), .rd_we(rd_we6), .rd_addr(rd_addr6), .wb_sel(wb_sel6),
        .rdata_out(rdata_out6), .misalign_err(mis6), .illegal_err(ill6), .mem_req(mem_req6),
        .mem_we(mem_we6), .mem_addr(mem_addr6), .mem_be(mem_be6), .mem_wdata(mem_wdata6),
        .mem_ack(ack6), .mem_rdata(rdata6)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] fn, input logic [4:0] rd);
        return {17'd0, fn, rd, op, 2'b11};
    endfunction

    initial begin
        iv = 0; inst = 0; addr = 0; wdata = 0; ack = 0; rdata = 0;
        iv6 = 0; inst6 = 0; addr6 = 0; wdata6 = 0; ack6 = 0; rdata6 = 0;
        repeat (2) cyc();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rdata_out", rdata_out, 0);
        chk("rst_mem_be", mem_be, 0);
        rst_n = 1;
        cyc();

        // ADDI x3, JAL x1, ADD x0 back to back
        iv = 1; inst = mk(5'b00100, 3'b000, 5'd3); #1 chk("b2b_stall_a", stall, 0);
        cyc();
        chk("addi_done", done, 1); chk("addi_wb_sel", wb_sel, 2'b01);
        chk("addi_rd_we", rd_we, 1); chk("addi_rd_addr", rd_addr, 3);
        inst = mk(5'b11011, 3'b000, 5'd1); #1 chk("b2b_stall_b", stall, 0);
        cyc();
        chk("jal_done", done, 1); chk("jal_wb_sel", wb_sel, 2'b10); chk("jal_rd_we", rd_we, 1);
        inst = mk(5'b01100, 3'b000, 5'd0); #1 chk("b2b_stall_c", stall, 0);
        cyc();
        chk("add_done", done, 1); chk("add_wb_sel", wb_sel, 2'b01); chk("add_rd_we_x0", rd_we, 0);
        iv = 0;
        cyc();
        chk("b2b_done_end", done, 0);

        // LB x5, 0x1003 with two wait cycles
        iv = 1; inst = mk(5'b00000, 3'b000, 5'd5); addr = 32'h1003; #1 chk("lb_accept_stall", stall, 1);
        cyc(); iv = 0;
        chk("lb_req", mem_req, 1); chk("lb_addr", mem_addr, 32'h1000);
        chk("lb_be", mem_be, 4'b1000); chk("lb_we", mem_we, 0); chk("lb_no_done", done, 0);
        cyc();
        chk("lb_wait1_req", mem_req, 1);
        cyc();
        chk("lb_wait2_req", mem_req, 1); chk("lb_wait2_addr", mem_addr, 32'h1000);
        ack = 1; rdata = 32'h80FF_FF12;
        cyc(); ack = 0; rdata = 0;
        chk("lb_done", done, 1); chk("lb_rdata", rdata_out, 32'hFFFF_FF80);
        chk("lb_wb_sel", wb_sel, 2'b00); chk("lb_rd_we", rd_we, 1);
        chk("lb_rd_addr", rd_addr, 5); chk("lb_req_drop", mem_req, 0);
        cyc();
        chk("lb_done_pulse", done, 0); chk("lb_stall_idle", stall, 0);

        // SH 0x2002, immediate ack
        iv = 1; inst = mk(5'b01000, 3'b001, 5'd7); addr = 32'h2002; wdata = 32'h1234_ABCD;
        #1 chk("sh_accept_stall", stall, 1);
        cyc(); iv = 0;
        chk("sh_req", mem_req, 1); chk("sh_be", mem_be, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hABCD_0000); chk("sh_we", mem_we, 1);
        chk("sh_addr", mem_addr, 32'h2000);
        ack = 1;
        cyc(); ack = 0;
        chk("sh_done", done, 1); chk("sh_rd_we", rd_we, 0); chk("sh_rdata", rdata_out, 0);
        chk("sh_req_drop", mem_req, 0);
        cyc();
        chk("sh_done_pulse", done, 0);

        // stray ack in IDLE is ignored
        ack = 1;
        cyc(); ack = 0;
        chk("stray_ack_done", done, 0); chk("stray_ack_req", mem_req, 0);

`ifdef MISALIGN_SPLIT_EN
        iv = 1; inst = mk(5'b00000, 3'b101, 5'd6); addr = 32'h3003; #1 chk("lhu_stall", stall, 1);
        cyc(); iv = 0;
        chk("lhu_b1_req", mem_req, 1); chk("lhu_b1_addr", mem_addr, 32'h3000);
        chk("lhu_b1_be", mem_be, 4'b1000);
        ack = 1; rdata = 32'hAB00_0000;
        cyc();
        chk("lhu_b2_req", mem_req, 1); chk("lhu_b2_addr", mem_addr, 32'h3004);
        chk("lhu_b2_be", mem_be, 4'b0001); chk("lhu_b2_no_done", done, 0);
        rdata = 32'h0000_00CD;
        cyc(); ack = 0; rdata = 0;
        chk("lhu_done", done, 1); chk("lhu_rdata", rdata_out, 32'h0000_CDAB);
        chk("lhu_mis", mis, 0); chk("lhu_rd_we", rd_we, 1);
`else
        iv = 1; inst = mk(5'b00000, 3'b101, 5'd6); addr = 32'h3001; #1 chk("lhu_stall", stall, 1);
        cyc(); iv = 0;
        chk("lhu_no_req", mem_req, 0); chk("lhu_done", done, 1); chk("lhu_mis", mis, 1);
        chk("lhu_rd_we", rd_we, 0); chk("lhu_ill", ill, 0);
`endif
        cyc();
        chk("lhu_done_pulse", done, 0); chk("lhu_mis_pulse", mis, 0);

        // LD on XLEN=32 is illegal
        iv = 1; inst = mk(5'b00000, 3'b011, 5'd4); addr = 32'h4000;
        cyc(); iv = 0;
        chk("ld32_ill", ill, 1); chk("ld32_done", done, 1);
        chk("ld32_no_req", mem_req, 0); chk("ld32_rd_we", rd_we, 0);
        cyc();

        // reset while an access is outstanding
        iv = 1; inst = mk(5'b00000, 3'b010, 5'd2); addr = 32'h5000;
        cyc(); iv = 0;
        chk("rstmid_req_before", mem_req, 1);
        #2 rst_n = 0;
        #1 chk("rstmid_req_async", mem_req, 0);
        cyc(); rst_n = 1;
        cyc();
        chk("rstmid_no_done", done, 0); chk("rstmid_stall", stall, 0); chk("rstmid_req", mem_req, 0);
        cyc();
        chk("rstmid_no_done2", done, 0);

        // XLEN=64 LWU 0x8004
        iv6 = 1; inst6 = mk(5'b00000, 3'b110, 5'd9); addr6 = 32'h8004;
        cyc(); iv6 = 0;
        chk("lwu64_req", mem_req6, 1); chk("lwu64_addr", mem_addr6, 32'h8000);
        chk("lwu64_be", mem_be6, 8'hF0);
        ack6 = 1; rdata6 = 64'hF000_0001_DEAD_BEEF;
        cyc(); ack6 = 0; rdata6 = 0;
        chk("lwu64_done", done6, 1); chk("lwu64_rdata", rdata_out6, 64'h0000_0000_F000_0001);
        chk("lwu64_rd_we", rd_we6, 1); chk("lwu64_ill", ill6, 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
